sound_sequencer: RTL
====================

Name: sound_sequencer

Overview:
- Owns the single piezo speaker and arbitrates it between two sources: the game controller's color tone (level request, held while a color is shown or pressed) and one-shot jingles (start, win, lose, high score).
- Sequences jingles as fixed 4-note melodies timed by an external millisecond TICK strobe, and generates the square wave with a half-period divider.
- Sits between the game controller, the tick generator and the speaker pin.

Parameters:
- DIV_W, 16, width of the half-period divider counter.
- HP_SHIFT, 0, right shift applied to every half-period table value; simulation uses 8 for speed.
- NOTE_LEN, 200, duration of each jingle note in TICK pulses (1..255).
- GAP_LEN, 30, silent gap between jingle notes in TICK pulses (1..255).

Ports:
- CLK  in  1  system clock, 12 MHz nominal.
- RST_N  in  1  reset; asynchronous assert, active-low.
- COLOR_REQ  in  1  level; request a color tone while high.
- COLOR  in  2  color to sound while COLOR_REQ is high.
- JINGLE_REQ  in  1  single-cycle pulse requesting a jingle.
- JINGLE_ID  in  2  jingle select: 0 start, 1 win, 2 lose, 3 high score.
- TICK  in  1  single-cycle duration strobe.
- SPK  out  1  square-wave output to the speaker.
- SPK_ENA  out  1  high while a non-rest pitch is being driven.
- BUSY  out  1  high while a jingle is in progress.
- ACK  out  1  one-cycle pulse, the cycle after a jingle request is accepted.

Behaviour:
- Reset: every output is 0; state is IDLE; all counters and latched IDs are 0. Reset asserted mid-jingle aborts the jingle immediately, with no completion and no ACK.
- Note codes (3 bits) and half-periods in cycles at 12 MHz:
  - 0 rest
  - 1 A4 13636
  - 2 C5 11472
  - 3 D5 10224
  - 4 E5 9104
  - 5 G5 7653
  - 6 A5 6818
  - 7 C6 5731
  - Effective half-period HP = table value >> HP_SHIFT.
- Color tones: COLOR 0..3 maps to note codes 1, 2, 4, 5.
- Jingle ROM:
  - start {2,4,5,7}
  - win {5,6,7,7}
  - lose {4,3,2,1}
  - high score {7,0,7,0}
- Priority, highest first: lose > win > high score > start > color tone.
- States:
  - IDLE: SPK=0, SPK_ENA=0.
    - JINGLE_REQ -> NOTE (note 0 of the jingle).
    - Else COLOR_REQ -> TONE.
  - TONE: plays the pitch for COLOR.
    - COLOR changing while COLOR_REQ stays high restarts the divider at the new pitch.
    - COLOR_REQ low -> IDLE next cycle.
    - JINGLE_REQ -> NOTE (jingle preempts the tone).
  - NOTE: plays ROM[id][idx].
    - The tick counter clears on entry; a TICK in the entry cycle is not counted.
    - After the NOTE_LEN-th counted TICK: if idx<3 -> GAP, else jingle done.
  - GAP: SPK=0, SPK_ENA=0.
    - After GAP_LEN counted TICKs: idx+1 -> NOTE.
  - Jingle done: COLOR_REQ high -> TONE, else IDLE.
- Divider:
  - Counter and SPK clear to 0 on entry to every NOTE and TONE.
  - The counter increments each cycle; at HP-1 it wraps to 0 and SPK toggles, giving a period of 2*HP cycles.
  - Rest notes hold SPK=0 and SPK_ENA=0 but still time NOTE_LEN.
- SPK_ENA and the first divider cycle start the cycle after the request (1-cycle latency).
- Jingle arbitration:
  - JINGLE_REQ in IDLE or TONE is always accepted.
  - During a jingle, a request of strictly higher priority aborts the current jingle and restarts at idx 0 with the new id. A request of equal or lower priority is dropped with no ACK.
  - JINGLE_REQ and COLOR_REQ in the same cycle: the jingle wins.
  - ACK pulses for one cycle, the cycle after each accepted request.
- BUSY=1 in NOTE and GAP only.
- Tick counters are 8 bits, compared against NOTE_LEN-1 / GAP_LEN-1 on a TICK.

Optional Feature:
- Macro SOUND_MUTE_EN.
- Defined: adds input port MUTE (1 bit). While MUTE=1, SPK and SPK_ENA are forced to 0 combinationally after the flops. State, timing, BUSY and ACK are unaffected.
- Undefined: no MUTE port; outputs behave exactly as above.

Decomposition:
- Package sound_pkg:
  - note-code typedef
  - half-period table
  - color-to-note map
  - jingle ID localparams
  - jingle ROM
  - priority function
  - state enum (IDLE, TONE, NOTE, GAP)
- One sub-module, tone_gen:
  - inputs: half-period, restart, enable
  - outputs: SPK
  - contents: divider counter and the SPK flop
  - The sequencer FSM, tick counters and arbitration stay in sound_sequencer.

Test Plan (HP_SHIFT=8, NOTE_LEN=4, GAP_LEN=2, TICK every 100 cycles):
- COLOR_REQ=1, COLOR=0: SPK_ENA=1 next cycle; SPK toggles every 53 cycles. COLOR->3 mid-tone: divider restarts and SPK toggles every 29 cycles. COLOR_REQ=0: SPK=0 and SPK_ENA=0 next cycle.
- JINGLE_REQ, ID=0, from IDLE:
  - ACK one cycle later; BUSY=1.
  - Half-periods 44, 35, 29, 22 in order, each note 4 ticks, with 2-tick silent gaps.
  - BUSY=0 after the 4th note, with no trailing gap.
- Win jingle at note 1, then JINGLE_REQ ID=2 (lose): ACK, restart at lose note 0 (hp 35). A later ID=0 request is dropped: no ACK, melody unchanged.
- JINGLE_REQ ID=3 with COLOR_REQ held high throughout: high-score melody plays first, rest notes give SPK_ENA=0 for 4 ticks, then the color tone resumes when BUSY falls.
- Assert RST_N=0 mid-note: SPK, SPK_ENA, BUSY and ACK go to 0 asynchronously. After release with no requests, the block stays IDLE.
- With SOUND_MUTE_EN defined, MUTE=1 during a start jingle: SPK=0 throughout, and the BUSY duration equals the unmuted run.

Source files
------------

// File: rtl/sound_sequencer_pkg.sv
// Shared types, pitch tables, jingle ROM and arbitration ranking for the
// speaker sequencer.
package sound_pkg;

   typedef logic [2:0] note_t;
   typedef logic [1:0] jingle_id_t;

   localparam jingle_id_t JID_START   = 2'd0;
   localparam jingle_id_t JID_WIN     = 2'd1;
   localparam jingle_id_t JID_LOSE    = 2'd2;
   localparam jingle_id_t JID_HISCORE = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      TONE,
      NOTE,
      GAP
   } state_t;

   // Half-period in 12 MHz cycles before HP_SHIFT scaling; code 0 is a rest.
   function automatic logic [15:0] half_period(input note_t n);
      logic [15:0] hp;
      case (n)
         3'd1:    hp = 16'd13636;
         3'd2:    hp = 16'd11472;
         3'd3:    hp = 16'd10224;
         3'd4:    hp = 16'd9104;
         3'd5:    hp = 16'd7653;
         3'd6:    hp = 16'd6818;
         3'd7:    hp = 16'd5731;
         default: hp = 16'd0;
      endcase
      return hp;
   endfunction

   function automatic note_t color_note(input logic [1:0] c);
      note_t n;
      case (c)
         2'd0:    n = 3'd1;
         2'd1:    n = 3'd2;
         2'd2:    n = 3'd4;
         default: n = 3'd5;
      endcase
      return n;
   endfunction

   function automatic note_t jingle_note(input jingle_id_t id, input logic [1:0] idx);
      note_t n;
      case ({id, idx})
         {JID_START,   2'd0}: n = 3'd2;
         {JID_START,   2'd1}: n = 3'd4;
         {JID_START,   2'd2}: n = 3'd5;
         {JID_START,   2'd3}: n = 3'd7;
         {JID_WIN,     2'd0}: n = 3'd5;
         {JID_WIN,     2'd1}: n = 3'd6;
         {JID_WIN,     2'd2}: n = 3'd7;
         {JID_WIN,     2'd3}: n = 3'd7;
         {JID_LOSE,    2'd0}: n = 3'd4;
         {JID_LOSE,    2'd1}: n = 3'd3;
         {JID_LOSE,    2'd2}: n = 3'd2;
         {JID_LOSE,    2'd3}: n = 3'd1;
         {JID_HISCORE, 2'd0}: n = 3'd7;
         {JID_HISCORE, 2'd1}: n = 3'd0;
         {JID_HISCORE, 2'd2}: n = 3'd7;
         default:             n = 3'd0;
      endcase
      return n;
   endfunction

   // Larger rank wins: lose > win > high score > start.
   function automatic logic [1:0] jingle_prio(input jingle_id_t id);
      logic [1:0] p;
      case (id)
         JID_LOSE:    p = 2'd3;
         JID_WIN:     p = 2'd2;
         JID_HISCORE: p = 2'd1;
         default:     p = 2'd0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Half-period divider and square-wave flop; restart or disable returns the
// divider and output to zero.
module tone_gen
   import sound_pkg::*;
#(
   parameter int unsigned DIV_W = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [DIV_W-1:0] HALF_PERIOD,
   input  logic             RESTART,
   input  logic             ENABLE,
   output logic             SPK
);

   logic [DIV_W-1:0] cnt;
   logic             spk_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt   <= '0;
         spk_q <= 1'b0;
      end else if (RESTART || !ENABLE) begin
         cnt   <= '0;
         spk_q <= 1'b0;
      end else if (cnt == HALF_PERIOD - 1'b1) begin
         cnt   <= '0;
         spk_q <= ~spk_q;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign SPK = spk_q;

endmodule

// File: rtl/sound_sequencer.sv
// Speaker arbiter: color tones and 4-note jingles timed by TICK.
// Optional SOUND_MUTE_EN adds a MUTE input that silences SPK/SPK_ENA.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned HP_SHIFT = 0,
   parameter int unsigned NOTE_LEN = 200,
   parameter int unsigned GAP_LEN  = 30
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       COLOR_REQ,
   input  logic [1:0] COLOR,
   input  logic       JINGLE_REQ,
   input  logic [1:0] JINGLE_ID,
   input  logic       TICK,
`ifdef SOUND_MUTE_EN
   input  logic       MUTE,
`endif
   output logic       SPK,
   output logic       SPK_ENA,
   output logic       BUSY,
   output logic       ACK
);

   localparam logic [7:0] NOTE_LAST = 8'(NOTE_LEN - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_LEN - 1);

   state_t     state, state_nxt;
   jingle_id_t jid, jid_nxt;
   logic [1:0] idx, idx_nxt;
   logic [7:0] tick_cnt, tick_nxt;
   logic [1:0] tone_color, color_nxt;
   logic       ack_q;
   logic       accept;
   logic       restart;
   logic       in_jingle;

   note_t            cur_note;
   note_t            play_note;
   logic [DIV_W-1:0] hp;
   logic             ena_int;
   logic             tone_spk;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         jid        <= '0;
         idx        <= '0;
         tick_cnt   <= '0;
         tone_color <= '0;
         ack_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         jid        <= jid_nxt;
         idx        <= idx_nxt;
         tick_cnt   <= tick_nxt;
         tone_color <= color_nxt;
         ack_q      <= accept;
      end
   end

   assign in_jingle = (state == NOTE) || (state == GAP);

   always_comb begin
      state_nxt = state;
      jid_nxt   = jid;
      idx_nxt   = idx;
      tick_nxt  = tick_cnt;
      color_nxt = tone_color;
      accept    = 1'b0;
      restart   = 1'b0;

      // A jingle request outranks every state transition below it.
      if (JINGLE_REQ && (!in_jingle || (jingle_prio(JINGLE_ID) > jingle_prio(jid)))) begin
         accept    = 1'b1;
         state_nxt = NOTE;
         jid_nxt   = JINGLE_ID;
         idx_nxt   = '0;
         tick_nxt  = '0;
         restart   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (COLOR_REQ) begin
                  state_nxt = TONE;
                  color_nxt = COLOR;
                  restart   = 1'b1;
               end
            end
            TONE: begin
               if (!COLOR_REQ) begin
                  state_nxt = IDLE;
               end else if (COLOR != tone_color) begin
                  color_nxt = COLOR;
                  restart   = 1'b1;
               end
            end
            NOTE: begin
               if (TICK) begin
                  if (tick_cnt == NOTE_LAST) begin
                     tick_nxt = '0;
                     if (idx != 2'd3) begin
                        state_nxt = GAP;
                     end else if (COLOR_REQ) begin
                        state_nxt = TONE;
                        color_nxt = COLOR;
                        restart   = 1'b1;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     tick_nxt = tick_cnt + 8'd1;
                  end
               end
            end
            GAP: begin
               if (TICK) begin
                  if (tick_cnt == GAP_LAST) begin
                     tick_nxt  = '0;
                     idx_nxt   = idx + 2'd1;
                     state_nxt = NOTE;
                     restart   = 1'b1;
                  end else begin
                     tick_nxt = tick_cnt + 8'd1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign cur_note  = jingle_note(jid, idx);
   assign play_note = (state == TONE) ? color_note(tone_color) : cur_note;
   assign hp        = DIV_W'(half_period(play_note) >> HP_SHIFT);
   assign ena_int   = (state == TONE) || ((state == NOTE) && (cur_note != 3'd0));

   tone_gen #(
      .DIV_W(DIV_W)
   ) u_tone_gen (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .HALF_PERIOD(hp),
      .RESTART    (restart),
      .ENABLE     (ena_int),
      .SPK        (tone_spk)
   );

`ifdef SOUND_MUTE_EN
   assign SPK     = tone_spk & ena_int & ~MUTE;
   assign SPK_ENA = ena_int & ~MUTE;
`else
   assign SPK     = tone_spk & ena_int;
   assign SPK_ENA = ena_int;
`endif
   assign BUSY = in_jingle;
   assign ACK  = ack_q;

endmodule
